// File: rtl/bnn_infer_ctrl.sv
// Sequencer between an image stream, a BNN core and a result FIFO.
// Latency: core_start one cycle after image acceptance; result visible on the core_done edge.
// Backpressure: img_ready drops while an inference is in flight or the result FIFO is full.
// Optional watchdog compiled in with macro BNN_TIMEOUT_EN.
module bnn_infer_ctrl #(
    parameter int IMG_W       = 30,
    parameter int IC          = 1,
    parameter int PAD_BITS    = 4,
    parameter int RES_W       = 4,
    parameter int RES_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [IC*IMG_W*IMG_W+PAD_BITS-1:0]   img_in,
    input  logic                                 img_valid,
    output logic                                 img_ready,
    output logic [IC*IMG_W*IMG_W-1:0]            core_img,
    output logic                                 core_start,
    input  logic                                 core_done,
    input  logic [RES_W-1:0]                     core_result,
    output logic [RES_W-1:0]                     result_out,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    input  logic                                 clear,
    output logic                                 busy,
    output logic [$clog2(RES_DEPTH):0]           res_count,
    output logic                                 timeout_err
);
    localparam int PIX_BITS = IC * IMG_W * IMG_W;
    localparam int PW       = $clog2(RES_DEPTH);
    localparam int CW       = $clog2(RES_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t                state_q;
    logic [PIX_BITS-1:0]   core_img_q;
    logic                  core_start_q;
    logic [RES_W-1:0]      mem_q [RES_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    // Pad bits carry no image data and are dropped on acceptance.
    logic unused_pad;
    assign unused_pad = ^img_in[PAD_BITS-1:0];

    // Only a RUN-state completion produces a result; acceptance guarantees a free slot.
    assign push = (state_q == RUN) && core_done;
    assign pop  = (cnt_q != '0) && result_ready;

    assign img_ready    = (state_q == IDLE) && (cnt_q < CW'(RES_DEPTH)) && !clear;
    assign busy         = (state_q != IDLE);
    assign core_img     = core_img_q;
    assign core_start   = core_start_q;
    assign result_valid = (cnt_q != '0);
    assign result_out   = mem_q[rptr_q];
    assign res_count    = cnt_q;

`ifdef BNN_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_q;
    logic            terr_q;
    assign timeout_err = terr_q;
`else
    logic unused_wd_cfg;
    assign unused_wd_cfg = (TIMEOUT_CYC > 0);
    assign timeout_err   = 1'b0;
`endif

    // Inference sequencing: accept image, pulse start, wait for completion (or watchdog).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            core_img_q   <= '0;
            core_start_q <= 1'b0;
`ifdef BNN_TIMEOUT_EN
            wd_q         <= '0;
            terr_q       <= 1'b0;
`endif
        end else if (clear) begin
            state_q      <= IDLE;
            core_start_q <= 1'b0;
`ifdef BNN_TIMEOUT_EN
            terr_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (img_valid && img_ready) begin
                        core_img_q   <= img_in[PIX_BITS+PAD_BITS-1:PAD_BITS];
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    core_start_q <= 1'b0;
                    state_q      <= RUN;
`ifdef BNN_TIMEOUT_EN
                    wd_q         <= '0;
`endif
                end
                RUN: begin
                    if (core_done) begin
                        state_q <= IDLE;
`ifdef BNN_TIMEOUT_EN
                    end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= IDLE;
                        terr_q  <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO pointer/occupancy next state; clear wins over any push or pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO pointer/occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage write; a flushed push is discarded.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) begin
            mem_q[wptr_q] <= core_result;
        end
    end
endmodule

// File: tb/tb_bnn_infer_ctrl.sv
module tb_bnn_infer_ctrl;
    localparam int IMG_W = 4, IC = 2, PAD = 4, RW = 4, DEPTH = 4, TO = 16;
    localparam int PIX = IC * IMG_W * IMG_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PIX+PAD-1:0] img_in = '0;
    logic              img_valid = 1'b0;
    logic              img_ready;
    logic [PIX-1:0]    core_img;
    logic              core_start;
    logic              core_done = 1'b0;
    logic [RW-1:0]     core_result = '0;
    logic [RW-1:0]     result_out;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic              clear = 1'b0;
    logic              busy;
    logic [2:0]        res_count;
    logic              timeout_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bnn_infer_ctrl #(.IMG_W(IMG_W), .IC(IC), .PAD_BITS(PAD), .RES_W(RW),
                     .RES_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .img_in(img_in), .img_valid(img_valid), .img_ready(img_ready),
        .core_img(core_img), .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .result_out(result_out), .result_valid(result_valid),
        .result_ready(result_ready), .clear(clear), .busy(busy), .res_count(res_count),
        .timeout_err(timeout_err));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [RW-1:0] mq[$];
    bit            m_start_pend;   // accepted, start pulse cycle pending
    bit            m_in_flight;    // core working on an image
    int            m_run_cyc;
    logic [PIX-1:0] m_img;
    bit            m_terr;
    bit            cmp_en = 1'b0;

    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (rst) begin
            mq.delete();
            m_start_pend = 1'b0;
            m_in_flight  = 1'b0;
            m_img        = '0;
            m_terr       = 1'b0;
        end else if (clear) begin
            mq.delete();
            m_start_pend = 1'b0;
            m_in_flight  = 1'b0;
            m_terr       = 1'b0;
        end else begin
            do_pop = (mq.size() > 0) && result_ready;
            if (m_start_pend) begin
                m_start_pend = 1'b0;
                m_in_flight  = 1'b1;
                m_run_cyc    = 0;
            end else if (m_in_flight) begin
                if (core_done) begin
                    do_push     = 1'b1;
                    m_in_flight = 1'b0;
`ifdef BNN_TIMEOUT_EN
                end else if (m_run_cyc == TO - 1) begin
                    m_in_flight = 1'b0;
                    m_terr      = 1'b1;
`endif
                end else begin
                    m_run_cyc++;
                end
            end else if (img_valid && mq.size() < DEPTH) begin
                m_img        = img_in[PIX+PAD-1:PAD];
                m_start_pend = 1'b1;
            end
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(core_result);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",         busy,         64'(m_start_pend || m_in_flight));
            chk("core_start",   core_start,   64'(m_start_pend));
            chk("img_ready",    img_ready,
                64'(!m_start_pend && !m_in_flight && mq.size() < DEPTH && !clear));
            chk("result_valid", result_valid, 64'(mq.size() > 0));
            chk("res_count",    res_count,    64'(mq.size()));
            chk("core_img",     core_img,     64'(m_img));
            chk("timeout_err",  timeout_err,  64'(m_terr));
            if (mq.size() > 0) chk("result_out", result_out, 64'(mq[0]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!img_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_wait: img_ready stayed %0b, expected 1", img_ready);
        end
    endtask

    task automatic accept(input logic [PIX-1:0] pix);
        wait_ready();
        img_in    = {pix, 4'hA};
        img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
    endtask

    task automatic infer(input logic [RW-1:0] res, input int dly);
        accept(PIX'(res) + 32'h100);
        repeat (dly) tick();
        core_done   = 1'b1;
        core_result = res;
        tick();
        core_done   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_img_ready", img_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_core_img", core_img, 0);
        rst = 1'b0;
        tick();

        // Basic inference: start pulse of one cycle, result 7.
        accept(32'h0000_0001);
        chk("start_hi", core_start, 1);
        chk("img_lsb", core_img, 32'h1);
        tick();
        chk("start_lo", core_start, 0);
        tick();
        tick();
        core_done = 1'b1; core_result = 4'd7;
        tick();
        core_done = 1'b0;
        chk("r7_out", result_out, 7);
        chk("r7_valid", result_valid, 1);
        chk("r7_count", res_count, 1);
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Fill FIFO, fifth image must stall, then drain in order.
        for (int i = 1; i <= 4; i++) infer(RW'(i), 2);
        img_in = {32'h5555_5555, 4'h0}; img_valid = 1'b1;
        tick(); tick();
        chk("full_ready", img_ready, 0);
        chk("full_count", res_count, 4);
        img_valid = 1'b0;
        result_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", result_out, 64'(i));
            tick();
        end
        result_ready = 1'b0;
        chk("drained", res_count, 0);

        // Simultaneous push and pop.
        infer(4'd5, 1);
        infer(4'd6, 3);
        accept(32'h0F0F_0F0F);
        tick();
        core_done = 1'b1; core_result = 4'd9; result_ready = 1'b1;
        tick();
        core_done = 1'b0;
        chk("pp_count", res_count, 2);
        chk("pp_head6", result_out, 6);
        tick();
        chk("pp_head9", result_out, 9);
        tick();
        result_ready = 1'b0;
        chk("pp_empty", res_count, 0);

        // Clear during RUN with three entries queued.
        for (int i = 1; i <= 3; i++) infer(RW'(i), 1);
        accept(32'h1234_5678);
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_count", res_count, 0);
        chk("clr_busy", busy, 0);
        chk("clr_valid", result_valid, 0);
        core_done = 1'b1; core_result = 4'd5; tick(); core_done = 1'b0;
        chk("late_done", res_count, 0);

        // Watchdog behaviour.
        accept(32'hCAFE_0001);
        tick();
        repeat (TO - 1) tick();
        chk("wd_busy15", busy, 1);
        tick();
`ifdef BNN_TIMEOUT_EN
        chk("wd_busy16", busy, 0);
        chk("wd_err", timeout_err, 1);
        chk("wd_count", res_count, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("wd_err_clr", timeout_err, 0);
        // Completion on the last watchdog cycle wins.
        accept(32'hCAFE_0002);
        tick();
        repeat (TO - 1) tick();
`else
        chk("nowd_busy", busy, 1);
        chk("nowd_err", timeout_err, 0);
`endif
        core_done = 1'b1; core_result = 4'd3; tick(); core_done = 1'b0;
        chk("wd_win_err", timeout_err, 0);
        chk("wd_win_count", res_count, 1);
        chk("wd_win_out", result_out, 3);
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Payload extraction with pad bits dropped.
        wait_ready();
        img_in = 36'hABCDEF125; img_valid = 1'b1; tick(); img_valid = 1'b0;
        chk("payload", core_img, 32'hABCDEF12);
        tick();
        core_done = 1'b1; core_result = 4'd2; tick(); core_done = 1'b0;
        result_ready = 1'b1; tick(); result_ready = 1'b0;

        // Reset mid-inference abandons it.
        accept(32'h0BAD_F00D);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        core_done = 1'b1; core_result = 4'd8; tick(); core_done = 1'b0;
        chk("rst_mid_count", res_count, 0);
        chk("rst_mid_img", core_img, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bnn_infer_ctrl.md
BNN_INFER_CTRL -- requirements
Module: bnn_infer_ctrl

Interface
REQ-001 Parameter IMG_W, default 30, image side length in pixels.
REQ-002 Parameter IC, default 1, input channel count; image payload is IC*IMG_W*IMG_W bits (PIX_BITS), channel 0 in the MSBs.
REQ-003 Parameter PAD_BITS, default 4, unused LSBs appended to the incoming image word.
REQ-004 Parameter RES_W, default 4, classification result width.
REQ-005 Parameter RES_DEPTH, default 4, result FIFO depth; power of two, at least 2.
REQ-006 Parameter TIMEOUT_CYC, default 4096, watchdog limit in cycles.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 img_in  in  PIX_BITS+PAD_BITS  image word; payload is img_in[PIX_BITS+PAD_BITS-1:PAD_BITS].
REQ-010 img_valid / img_ready  in / out  1  image handshake.
REQ-011 core_img  out  PIX_BITS  registered payload held stable for the BNN core.
REQ-012 core_start  out  1  one-cycle inference start pulse.
REQ-013 core_done / core_result  in / in  1 / RES_W  core completion strobe and result.
REQ-014 result_out / result_valid / result_ready  out / out / in  RES_W / 1 / 1  result FIFO head and handshake.
REQ-015 clear  in  1  synchronous flush request.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 res_count  out  $clog2(RES_DEPTH)+1  number of FIFO entries.
REQ-018 timeout_err  out  1  sticky watchdog flag.

Function
REQ-019 The FSM SHALL have the states IDLE, START and RUN.
REQ-020 img_ready SHALL equal (state==IDLE && res_count<RES_DEPTH && !clear).
REQ-021 An image is accepted on the edge where img_valid&&img_ready; on that edge the payload SHALL load into core_img and the FSM SHALL enter START. PAD bits are discarded.
REQ-022 In START, core_start SHALL be high for exactly that one cycle; the FSM then enters RUN.
REQ-023 In RUN, core_done SHALL push core_result into the FIFO on the same edge and return the FSM to IDLE. core_done outside RUN SHALL be ignored.
REQ-024 core_img SHALL stay unchanged from acceptance until the next acceptance.
REQ-025 result_valid SHALL equal (res_count!=0); result_out SHALL be the oldest entry. A pop occurs on result_valid&&result_ready.
REQ-026 On a simultaneous push and pop, res_count SHALL stay unchanged and order SHALL be preserved; read and write pointers wrap modulo RES_DEPTH.
REQ-027 Because acceptance requires a free FIFO slot, a push SHALL never find the FIFO full.
REQ-028 Latency: acceptance at edge N puts core_start high in cycle N+1. core_done sampled at edge M makes result_valid high from M onward when the FIFO was empty.
REQ-029 clear SHALL empty the FIFO, force IDLE, drop core_start and clear timeout_err on the next edge. It overrides every event except rst, including a coincident push or pop.

Reset
REQ-030 rst SHALL set the state to IDLE and set core_img, core_start, FIFO pointers, res_count, timeout_err and the watchdog counter to 0. busy and result_valid are then 0; img_ready is 1 in the first cycle after reset.
REQ-031 rst asserted mid-inference SHALL abandon it; a later core_done for that inference SHALL be ignored.

Configuration
REQ-032 Macro BNN_TIMEOUT_EN defined: a counter SHALL clear on entry to RUN and increment each RUN cycle. When it reaches TIMEOUT_CYC-1 without core_done, the FSM SHALL return to IDLE, set timeout_err, and push nothing. core_done on that same cycle wins: the result is pushed and no error is set.
REQ-033 Macro BNN_TIMEOUT_EN undefined: no counter exists, timeout_err is tied to 0, and RUN waits indefinitely.

Verification
REQ-034 After rst, send an image with payload LSB=1 and core_done=1/core_result=7 three cycles after core_start. Required: core_start high for exactly 1 cycle, then result_out=7, result_valid=1, res_count=1.
REQ-035 With result_ready=0, run 4 inferences (results 1,2,3,4), then offer a 5th image. Required: img_ready=0 and res_count=4. Then pop while holding result_ready=1; outputs read 1,2,3,4 in order.
REQ-036 With res_count=2, assert result_ready on the same edge a core_done pushes 9. Required: res_count stays 2, and 9 appears after the two older entries.
REQ-037 Assert clear with res_count=3 while in RUN. Required: next cycle res_count=0, busy=0, result_valid=0; a late core_done is ignored.
REQ-038 With BNN_TIMEOUT_EN and TIMEOUT_CYC=16, never assert core_done. Required: the FSM returns to IDLE 16 cycles after entering RUN, timeout_err=1, res_count unchanged; clear returns timeout_err to 0.
REQ-039 With IC=2 and IMG_W=4 (PIX_BITS=32), feed img_in=36'hABCDEF12_5. Required: core_img=32'hABCDEF12.
